// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-stream buffer depth, occupancy type and default word width.
package fifo_pkg;

  localparam int unsigned FIFO_RD_STREAM_DEPTH = 3;
  localparam int unsigned FIFO_OCC_WIDTH       = 2;
  localparam int unsigned FIFO_DEFAULT_WIDTH   = 8;

  typedef logic [FIFO_OCC_WIDTH-1:0] occ_t;

  // Circular index increment over the FIFO_RD_STREAM_DEPTH entries.
  function automatic occ_t idx_inc(input occ_t idx);
    return (idx == occ_t'(FIFO_RD_STREAM_DEPTH - 1)) ? occ_t'(0) : idx + occ_t'(1);
  endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Three-entry register buffer with head/tail indices; push at tail, pop from head.
module fifo_rd_skid_buf
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = FIFO_DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_data_o,
  output occ_t             count_o
);

  logic [WIDTH-1:0] mem_q [FIFO_RD_STREAM_DEPTH];
  logic [WIDTH-1:0] mem_d [FIFO_RD_STREAM_DEPTH];
  occ_t             head_q, head_d;
  occ_t             tail_q, tail_d;
  occ_t             count_q, count_d;
  logic             pop_ok;

  assign pop_ok = pop_i && (count_q != occ_t'(0));

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + occ_t'(push_i) - occ_t'(pop_ok);
    if (push_i) begin
      for (int unsigned i = 0; i < FIFO_RD_STREAM_DEPTH; i++) begin
        if (tail_q == occ_t'(i)) begin
          mem_d[i] = push_data_i;
        end
      end
      tail_d = idx_inc(tail_q);
    end
    if (pop_ok) begin
      head_d = idx_inc(head_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < FIFO_RD_STREAM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int unsigned i = 0; i < FIFO_RD_STREAM_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    head_data_o = '0;
    for (int unsigned i = 0; i < FIFO_RD_STREAM_DEPTH; i++) begin
      if (head_q == occ_t'(i)) begin
        head_data_o = mem_q[i];
      end
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-port to valid/ready stream adapter with a 3-word local buffer.
// Optional delivered-word counter enabled by defining FIFO_RD_STREAM_STATS_EN.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = FIFO_DEFAULT_WIDTH,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst,
  input  logic                 fifo_empty,
  input  logic [WIDTH-1:0]     fifo_data,
  output logic                 fifo_rd_en,
  output logic                 m_valid,
  output logic [WIDTH-1:0]     m_data,
  input  logic                 m_ready
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] word_count
`endif
);

  if (CNT_WIDTH == 0) begin : g_cnt_width_check
    $error("CNT_WIDTH must be non-zero");
  end

  logic       inflight_q, inflight_d;
  occ_t       held;
  logic [2:0] pending;
  logic       pop;

  // Issue depends only on registered occupancy and fifo_empty, never on m_ready, so a
  // word already in flight always has a free slot to land in.
  assign pending    = {1'b0, held} + {2'b00, inflight_q};
  assign fifo_rd_en = !fifo_empty && (pending <= 3'd2) && !rd_rst;
  assign inflight_d = fifo_rd_en;

  assign m_valid = (held != occ_t'(0));
  assign pop     = m_valid && m_ready;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  fifo_rd_skid_buf #(
    .WIDTH(WIDTH)
  ) u_skid_buf (
    .clk_i      (rd_clk),
    .rst_i      (rd_rst),
    .push_i     (inflight_q),
    .push_data_i(fifo_data),
    .pop_i      (pop),
    .head_data_o(m_data),
    .count_o    (held)
  );

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [CNT_WIDTH-1:0] word_count_q, word_count_d;

  always_comb begin
    word_count_d = word_count_q;
    if (pop) begin
      word_count_d = word_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      word_count_q <= '0;
    end else begin
      word_count_q <= word_count_d;
    end
  end

  assign word_count = word_count_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: directed vector table plus FIFO-model sequences.
module tb_fifo_rd_stream;

  logic       rd_clk = 1'b0;
  logic       rd_rst;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd_en;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;

  always #5 rd_clk = ~rd_clk;

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [15:0] word_count;
  logic [2:0]  wc3;
  logic        rd_en3, v3;
  logic [7:0]  d3;

  fifo_rd_stream #(.WIDTH(8), .CNT_WIDTH(16)) u_dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .word_count(word_count)
  );

  fifo_rd_stream #(.WIDTH(8), .CNT_WIDTH(3)) u_dut3 (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(rd_en3), .m_valid(v3), .m_data(d3), .m_ready(m_ready),
    .word_count(wc3)
  );
`else
  fifo_rd_stream #(.WIDTH(8), .CNT_WIDTH(16)) u_dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready)
  );
`endif

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // FIFO model and scoreboard state
  logic [7:0] q[$];
  logic [7:0] outq[$];
  int         fire_ticks[$];
  bit         use_model;
  bit         toggle_en;
  bit         gate;
  int         tcount;
  logic       s_rd_en, s_valid, s_fire;
  logic [7:0] s_data;

  // Sample just before the edge, advance, then update the FIFO model after the edge.
  task automatic tick();
    #1;
    s_rd_en = fifo_rd_en;
    s_valid = m_valid;
    s_data  = m_data;
    s_fire  = m_valid && m_ready;
    chk("rd_en_while_empty", {31'b0, fifo_rd_en & fifo_empty}, 32'd0);
    @(posedge rd_clk);
    #1;
    tcount++;
    if (s_fire) begin
      outq.push_back(s_data);
      fire_ticks.push_back(tcount);
    end
    if (use_model) begin
      if (s_rd_en) fifo_data = (q.size() > 0) ? q.pop_front() : 8'hEE;
      if (toggle_en && (tcount % 3 == 0)) gate = !gate;
      fifo_empty = gate || (q.size() == 0);
    end
  endtask

  task automatic do_reset();
    rd_rst     = 1'b1;
    use_model  = 1'b0;
    toggle_en  = 1'b0;
    gate       = 1'b0;
    q.delete();
    fifo_empty = 1'b1;
    fifo_data  = 8'h00;
    m_ready    = 1'b0;
    @(posedge rd_clk);
    #1;
    rd_rst = 1'b0;
    outq.delete();
    fire_ticks.delete();
  endtask

  task automatic check_seq(input string name, input logic [7:0] base, input int n);
    chk({name, "_count"}, outq.size(), n);
    for (int i = 0; i < n; i++) begin
      chk(name, (i < outq.size()) ? {24'b0, outq[i]} : 32'hDEAD, {24'b0, base + 8'(i)});
    end
  endtask

  typedef struct packed {
    logic       empty;
    logic [7:0] data;
    logic       ready;
    logic       exp_rd_en;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       chk_data;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_rd, first_v, nrd, maxgap, bound;
    logic       prev_stall;
    logic [7:0] prev_data;

    tcount = 0;
    // empty, data, ready | rd_en, valid, data, chk_data
    vecs[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[2]  = '{1'b0, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[3]  = '{1'b0, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1};
    vecs[4]  = '{1'b0, 8'h33, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1};
    vecs[5]  = '{1'b0, 8'h99, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1};
    vecs[6]  = '{1'b0, 8'h99, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1};
    vecs[7]  = '{1'b0, 8'h99, 1'b1, 1'b1, 1'b1, 8'h22, 1'b1};
    vecs[8]  = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 8'h33, 1'b1};
    vecs[9]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h44, 1'b1};
    vecs[10] = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 8'h44, 1'b1};
    vecs[11] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};

    // Reset with an empty FIFO
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_rd_en", {31'b0, s_rd_en}, 32'd0);
      chk("idle_valid", {31'b0, s_valid}, 32'd0);
      chk("idle_data", {24'b0, s_data}, 32'd0);
    end

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      fifo_empty = vecs[i].empty;
      fifo_data  = vecs[i].data;
      m_ready    = vecs[i].ready;
      tick();
      chk("vec_rd_en", {31'b0, s_rd_en}, {31'b0, vecs[i].exp_rd_en});
      chk("vec_valid", {31'b0, s_valid}, {31'b0, vecs[i].exp_valid});
      if (vecs[i].chk_data) chk("vec_data", {24'b0, s_data}, {24'b0, vecs[i].exp_data});
    end

    // Streaming with m_ready high
    do_reset();
    for (int i = 1; i <= 8; i++) q.push_back(8'(i));
    use_model  = 1'b1;
    fifo_empty = 1'b0;
    m_ready    = 1'b1;
    first_rd   = -1;
    first_v    = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s_rd_en && first_rd < 0) first_rd = tcount;
      if (s_valid && first_v < 0) first_v = tcount;
    end
    chk("stream_latency", 32'(first_v - first_rd), 32'd2);
    check_seq("stream_data", 8'h01, 8);
    if (fire_ticks.size() == 8) chk("stream_back_to_back", 32'(fire_ticks[7] - fire_ticks[0]), 32'd7);
    else chk("stream_back_to_back", 32'(fire_ticks.size()), 32'd8);
`ifdef FIFO_RD_STREAM_STATS_EN
    chk("stats_count8", {16'b0, word_count}, 32'd8);
    q.push_back(8'h09);
    fifo_empty = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("stats_count9", {16'b0, word_count}, 32'd9);
    chk("stats_wrap3", {29'b0, wc3}, 32'd1);
`endif

    // Backpressure: exactly three reads while m_ready is low
    do_reset();
    for (int i = 1; i <= 8; i++) q.push_back(8'(i));
    use_model  = 1'b1;
    fifo_empty = 1'b0;
    nrd        = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (s_rd_en) nrd++;
    end
    chk("bp_reads", 32'(nrd), 32'd3);
    chk("bp_hold_valid", {31'b0, s_valid}, 32'd1);
    chk("bp_hold_data", {24'b0, s_data}, 32'h01);
    m_ready = 1'b1;
    bound   = 0;
    while (outq.size() < 8 && bound < 40) begin
      tick();
      bound++;
    end
    check_seq("bp_data", 8'h01, 8);
    maxgap = 0;
    for (int i = 1; i < fire_ticks.size(); i++) begin
      if (fire_ticks[i] - fire_ticks[i-1] > maxgap) maxgap = fire_ticks[i] - fire_ticks[i-1];
    end
    chk("bp_restart_gap", {31'b0, maxgap <= 2}, 32'd1);

    // Empty toggling every 3 cycles with random m_ready
    do_reset();
    for (int i = 0; i < 32; i++) q.push_back(8'h10 + 8'(i));
    use_model  = 1'b1;
    toggle_en  = 1'b1;
    fifo_empty = 1'b0;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    bound      = 0;
    while (outq.size() < 32 && bound < 400) begin
      m_ready = 1'($urandom_range(0, 1));
      tick();
      if (prev_stall) begin
        chk("toggle_hold_valid", {31'b0, s_valid}, 32'd1);
        chk("toggle_hold_data", {24'b0, s_data}, {24'b0, prev_data});
      end
      prev_stall = s_valid && !s_fire;
      prev_data  = s_data;
      bound++;
    end
    check_seq("toggle_data", 8'h10, 32);

    // Reset with held = 2 and one read in flight
    do_reset();
    for (int i = 0; i < 8; i++) q.push_back(8'h50 + 8'(i));
    use_model  = 1'b1;
    fifo_empty = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    #1;
    chk("pre_reset_rd_en", {31'b0, fifo_rd_en}, 32'd0);
    chk("pre_reset_valid", {31'b0, m_valid}, 32'd1);
    #1;
    rd_rst = 1'b1;
    #1;
    chk("mid_reset_valid", {31'b0, m_valid}, 32'd0);
    chk("mid_reset_rd_en", {31'b0, fifo_rd_en}, 32'd0);
    chk("mid_reset_data", {24'b0, m_data}, 32'd0);
    q.delete();
    fifo_empty = 1'b1;
    fifo_data  = 8'h00;
    @(posedge rd_clk);
    #1;
    rd_rst = 1'b0;
    outq.delete();
    fire_ticks.delete();
    for (int i = 0; i < 4; i++) q.push_back(8'hA0 + 8'(i));
    fifo_empty = 1'b0;
    m_ready    = 1'b1;
    bound      = 0;
    while (outq.size() < 4 && bound < 20) begin
      tick();
      bound++;
    end
    check_seq("after_reset_data", 8'hA0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side drain engine for the team's FIFOs, both synchronous and asynchronous. It runs in the read clock domain and issues `rd_en` against the FIFO's registered read port (`data_out` / `empty`, one-cycle read latency). It converts that port into a valid/ready stream with full throughput and no loss or duplication. It holds up to three words locally so that `fifo_rd_en` never depends combinationally on `m_ready`.

## Interface
Parameters:
- `WIDTH`, 8: data word width; must match the attached FIFO's `WIDTH`.
- `CNT_WIDTH`, 16: width of the delivered-word counter. Used only when `FIFO_RD_STREAM_STATS_EN` is defined.

Ports:
- `rd_clk`  in  1  read-domain clock; one clock only.
- `rd_rst`  in  1  asynchronous, active-high reset.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_data`  in  `WIDTH`  FIFO `data_out`. Valid the cycle after an accepted `fifo_rd_en`.
- `fifo_rd_en`  out  1  FIFO `rd_en`.
- `m_valid`  out  1  stream word available.
- `m_data`  out  `WIDTH`  stream word.
- `m_ready`  in  1  downstream accepts the word.
- `word_count`  out  `CNT_WIDTH`  words delivered. Present only with `FIFO_RD_STREAM_STATS_EN`.

## Operation
- State:
  - `held` in 0..3: words in the local buffer.
  - `inflight` in 0..1: a read was issued last cycle and its data is due on `fifo_data` this cycle.
- Issue rule: `fifo_rd_en = !fifo_empty && (held + inflight <= 2) && !rd_rst`. It is combinational from registered state and `fifo_empty` only.
- Capture: when `inflight` = 1, `fifo_data` is written into the buffer tail at the next edge.
- Pop: `m_valid && m_ready` removes the head at the edge.
- Push and pop in the same cycle: `held` is unchanged, the head advances, and the new word goes behind the remaining words.
- `held` update: `held_next = held + inflight - pop`. It never exceeds 3; the issue rule guarantees this.
- Outputs:
  - `m_valid = (held != 0)`.
  - `m_data` = head entry. It is stable while `m_valid && !m_ready`.
- Order: words are delivered strictly in FIFO order. No drop and no duplicate while `rd_rst` is low.
- Empty FIFO: no issue, no capture. `m_valid` falls once `held` reaches 0.
- Reset:
  - `held`, `inflight`, buffer and `word_count` clear to 0 immediately.
  - `m_valid` = 0, `m_data` = 0, `fifo_rd_en` = 0.
  - A word already popped from the FIFO but not yet delivered is discarded. This is the required behaviour; the FIFO side is reset together with this block.

## Timing
- Read issued in cycle N (`fifo_rd_en` = 1 at edge N) produces `m_valid` = 1 after edge N+1. Latency is 2 edges from issue.
- Sustained throughput is one word per `rd_clk` with `m_ready` held high and the FIFO non-empty.
- `m_ready` dropping stops issue after at most 3 buffered words: `held` = 3, or `held` = 2 plus one in flight.
- `m_ready` rising with `held` = 3 gives the first pop at the same edge. Issue restarts in the following cycle.
- No combinational path from `m_ready` to `fifo_rd_en`.

## Configuration
- `FIFO_RD_STREAM_STATS_EN` defined:
  - `word_count` port exists.
  - It increments by 1 on every `m_valid && m_ready`.
  - It wraps modulo 2^`CNT_WIDTH`.
  - It clears on `rd_rst`.
- Not defined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package `fifo_pkg` holds:
  - `FIFO_RD_STREAM_DEPTH` = 3.
  - Occupancy width (2 bits).
  - The default `WIDTH`.
- One sub-module, `fifo_rd_skid_buf`, holds the 3-entry register buffer with head/tail indices and push/pop.
- The issue logic, the `inflight` flag and the stats counter stay in `fifo_rd_stream`.

## Test plan
- **Reset, FIFO empty:** `rd_rst` pulse, `fifo_empty` = 1 for 20 cycles -> `fifo_rd_en` = 0, `m_valid` = 0, `m_data` = 0 throughout.
- **Streaming:** FIFO preloaded with 0x01..0x08, `m_ready` = 1 -> first `m_valid` 2 edges after the first `fifo_rd_en`. Then 0x01..0x08 on 8 consecutive cycles, and `fifo_rd_en` is never asserted while `fifo_empty` = 1.
- **Backpressure:** same data with `m_ready` = 0 -> `fifo_rd_en` issues exactly 3 reads and `m_data` holds 0x01. After `m_ready` = 1, the sequence is 0x01..0x08 with no gap longer than 1 cycle at restart and no duplicates.
- **Empty mid-stream:** `fifo_empty` toggling every 3 cycles with random `m_ready` -> output order matches input order, and `m_valid` drops only when the buffer drains.
- **Reset mid-operation:** `held` = 2 and `inflight` = 1, then assert `rd_rst` between edges -> `m_valid` and `fifo_rd_en` go to 0 immediately. After release with a refilled FIFO (0xA0..), the first delivered word is 0xA0.
- **Stats (macro defined):** deliver 8 words -> `word_count` = 8. With `CNT_WIDTH` = 3, delivering 9 words gives `word_count` = 1.
